// File: rtl/ks_pkg.sv
// Shared definitions for the Kogge-Stone adder: operand width, a compile-time
// log2 helper and the generate/propagate pair carried through the prefix tree.
package ks_pkg;

    localparam int KS_WIDTH = 8;

    // Ceiling log2; the result is the number of prefix levels.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/ks_gp_cell.sv
// Black cell of the prefix tree: merges a higher-order (g,p) span with the
// adjacent lower-order span into one combined span.
module ks_gp_cell
    import ks_pkg::*;
(
    input  gp_t gp_hi,
    input  gp_t gp_lo,
    output gp_t gp_out
);

    assign gp_out.g = gp_hi.g | (gp_hi.p & gp_lo.g);
    assign gp_out.p = gp_hi.p & gp_lo.p;

endmodule

// File: rtl/kogge_stone_8.sv
// 8-bit Kogge-Stone adder: combinational prefix core computing a+b+ci,
// followed by a single output register holding {co,s}.
module kogge_stone_8
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int LEVELS = clog2(WIDTH);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    // lvl[k] holds the (G,P) spans after k prefix levels.
    gp_t [WIDTH-1:0] lvl [LEVELS+1];

    assign g = a & b;
    assign p = a ^ b;

    // Carry-in enters as the generate term of position -1, folded into bit 0.
    assign lvl[0][0].g = g[0] | (p[0] & ci);
    assign lvl[0][0].p = p[0];

    genvar i, k;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_pre
            assign lvl[0][i].g = g[i];
            assign lvl[0][i].p = p[i];
        end

        for (k = 0; k < LEVELS; k++) begin : g_level
            localparam int D = 1 << k;
            for (i = 0; i < WIDTH; i++) begin : g_bit
                if (i >= D) begin : g_cell
                    ks_gp_cell u_cell (
                        .gp_hi (lvl[k][i]),
                        .gp_lo (lvl[k][i-D]),
                        .gp_out(lvl[k+1][i])
                    );
                end else begin : g_buf
                    assign lvl[k+1][i] = lvl[k][i];
                end
            end
        end

        assign c[0] = ci;
        for (i = 1; i <= WIDTH; i++) begin : g_carry
            assign c[i] = lvl[LEVELS][i-1].g;
        end
    endgenerate

    assign sum = p ^ c[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s  <= '0;
            co <= 1'b0;
        end else begin
            s  <= sum;
            co <= c[WIDTH];
        end
    end

endmodule

// File: tb/tb_kogge_stone_8.sv
// Bench for kogge_stone_8: driver pushes a+b+ci into a queue, a monitor pops
// and compares after every edge; reset behaviour is checked directly.
module tb_kogge_stone_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;

    logic [8:0] exp_q[$];
    int n_vec;
    int n_err;

    kogge_stone_8 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .ci   (ci),
        .s    (s),
        .co   (co)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                           input logic c);
        int total;
        total = int'(x) + int'(y) + int'(c);
        return total[8:0];
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input logic [7:0] x, input logic [7:0] y, input logic c);
        @(negedge clk);
        a  = x;
        b  = y;
        ci = c;
        exp_q.push_back(ref_add(x, y, c));
    endtask

    task automatic check_now(input string name, input logic [8:0] want);
        n_vec++;
        if ({co, s} !== want) begin
            n_err++;
            $display("FAIL %s: got co=%0b s=%0d, expected co=%0b s=%0d",
                     name, co, s, want[8], want[7:0]);
        end
    endtask

    task automatic drain(input string name);
        int cycles;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 10) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: %0d results never appeared, expected 0 pending",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic [8:0] want;
        #1;
        if (rst_n && exp_q.size() != 0) begin
            want = exp_q.pop_front();
            n_vec++;
            if ({co, s} !== want) begin
                n_err++;
                $display("FAIL sum: got co=%0b s=%0d, expected co=%0b s=%0d",
                         co, s, want[8], want[7:0]);
            end
        end
    end

    // ---------------- directed table ----------------
    logic [7:0] da [12] = '{8'd5, 8'd37, 8'd125, 8'd122, 8'd245, 8'd3,
                            8'd63, 8'd100, 8'd255, 8'd255, 8'd127, 8'd128};
    logic [7:0] db [12] = '{8'd10, 8'd48, 8'd110, 8'd11, 8'd2, 8'd90,
                            8'd211, 8'd200, 8'd255, 8'd0, 8'd127, 8'd128};
    logic       dc [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        a  = 8'd5;
        b  = 8'd10;
        ci = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_now("reset_async", 9'd0);
        repeat (3) @(posedge clk);
        #1 check_now("reset_held", 9'd0);

        // Release between edges; the first edge captures the current sum.
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(ref_add(8'd5, 8'd10, 1'b1));
        drain("reset_release");
        if (s !== 8'd16) begin
            n_vec++;
            n_err++;
            $display("FAIL release_sum: got s=%0d, expected s=16", s);
        end else begin
            n_vec++;
        end

        for (int i = 0; i < 12; i++) apply(da[i], db[i], dc[i]);
        drain("directed");

        for (int i = 0; i < 1000; i++)
            apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        drain("random");

        // Asynchronous reset between edges, then release mid-stream.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_now("reset_midstream", 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a  = 8'd200;
        b  = 8'd100;
        ci = 1'b1;
        exp_q.push_back(ref_add(8'd200, 8'd100, 1'b1));
        for (int i = 0; i < 20; i++)
            apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
